// File: rtl/struct_rx_unpack_if.sv
// Beat-in / word-out channel for the packed-struct receive endpoint.
// The slave modport is the unpacker itself; the master modport is the surrounding harness.
interface struct_rx_unpack_if #(
    parameter int BEATS = 4
);
    localparam int CNT_W = $clog2(BEATS) + 1;

    logic [7:0]         i_a;
    logic               i_a_valid;
    logic               o_a_ready;
    logic [4*BEATS-1:0] o_word;
    logic [2:0]         o_tag;
    logic [CNT_W-1:0]   o_nbeats;
    logic               o_err;
    logic               o_valid;
    logic               i_ready;

    modport master (
        output i_a, i_a_valid, i_ready,
        input  o_a_ready, o_word, o_tag, o_nbeats, o_err, o_valid
    );

    modport slave (
        input  i_a, i_a_valid, i_ready,
        output o_a_ready, o_word, o_tag, o_nbeats, o_err, o_valid
    );
endinterface

// File: rtl/struct_rx_unpack.sv
// Collects {last, tag, nibble} beats into one word of up to BEATS nibbles.
// The finished word is presented through a registered valid/ready output stage.
module struct_rx_unpack #(
    parameter int BEATS = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    struct_rx_unpack_if.slave bus
);
    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam int W     = 4 * BEATS;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(BEATS - 1);

    logic [W-1:0]     acc;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       first_tag;
    logic             err_acc;

    logic [W-1:0]     word_q;
    logic [2:0]       tag_q;
    logic [CNT_W-1:0] nbeats_q;
    logic             err_q;
    logic             valid_q;

    logic             a_ready;
    logic             beat_fire;
    logic             out_fire;
    logic             complete;
    logic             mismatch;
    logic [2:0]       cur_tag;
    logic [2:0]       word_tag;
    logic [3:0]       cur_nib;
    logic [W-1:0]     merged;

    // Accepting a beat needs a free or freeing output slot, so a completing beat never stalls.
    assign a_ready   = !i_rst && (!valid_q || bus.i_ready);
    assign beat_fire = bus.i_a_valid && a_ready;
    assign out_fire  = valid_q && bus.i_ready;
    assign cur_tag   = bus.i_a[6:4];
    assign cur_nib   = bus.i_a[3:0];
    assign mismatch  = (cnt != '0) && (cur_tag != first_tag);
    assign word_tag  = (cnt == '0) ? cur_tag : first_tag;
    assign complete  = beat_fire && (bus.i_a[7] || (cnt == LAST_SLOT));

    always_comb begin
        merged = acc;
        for (int k = 0; k < BEATS; k++) begin
            if (CNT_W'(k) == cnt) begin
                merged[4*k +: 4] = cur_nib;
            end else if (CNT_W'(k) > cnt) begin
                merged[4*k +: 4] = 4'h0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc       <= '0;
            cnt       <= '0;
            first_tag <= '0;
            err_acc   <= 1'b0;
        end else if (beat_fire) begin
            if (complete) begin
                acc     <= '0;
                cnt     <= '0;
                err_acc <= 1'b0;
            end else begin
                acc <= merged;
                cnt <= cnt + CNT_W'(1);
                if (cnt == '0) begin
                    first_tag <= cur_tag;
                    err_acc   <= 1'b0;
                end else begin
                    err_acc <= err_acc | mismatch;
                end
            end
        end
    end

    // A completion in the same cycle as an output transfer simply overwrites the old word.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            word_q   <= '0;
            tag_q    <= '0;
            nbeats_q <= '0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else if (complete) begin
            word_q   <= merged;
            tag_q    <= word_tag;
            nbeats_q <= cnt + CNT_W'(1);
            err_q    <= err_acc | mismatch;
            valid_q  <= 1'b1;
        end else if (out_fire) begin
            valid_q  <= 1'b0;
        end
    end

    assign bus.o_a_ready = a_ready;
    assign bus.o_word    = word_q;
    assign bus.o_tag     = tag_q;
    assign bus.o_nbeats  = nbeats_q;
    assign bus.o_err     = err_q;
    assign bus.o_valid   = valid_q;
endmodule

// File: tb/tb_struct_rx_unpack.sv
// Scenario bench for struct_rx_unpack against a beat-queue reference model.
// Each task drives its scenario and compares DUT outputs inline.
module tb_struct_rx_unpack;
    localparam int BEATS = 4;
    localparam int CNT_W = 3;
    localparam int W     = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    struct_rx_unpack_if #(.BEATS(BEATS)) bus ();

    struct_rx_unpack #(.BEATS(BEATS)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Reference model: beats of the word in progress, plus the word being presented.
    logic [7:0]       partial[$];
    logic             m_valid  = 1'b0;
    logic [W-1:0]     m_word   = '0;
    logic [2:0]       m_tag    = '0;
    logic [CNT_W-1:0] m_nbeats = '0;
    logic             m_err    = 1'b0;

    task automatic drive_cycle(input logic r_rst, input logic v, input logic [7:0] a, input logic r);
        logic       ready_exp;
        logic [2:0] t0;
        rst           = r_rst;
        bus.i_a_valid = v;
        bus.i_a       = a;
        bus.i_ready   = r;
        ready_exp     = !r_rst && (!m_valid || r);
        if (r_rst) begin
            partial.delete();
            m_valid = 1'b0; m_word = '0; m_tag = '0; m_nbeats = '0; m_err = 1'b0;
        end else begin
            if (m_valid && r) m_valid = 1'b0;
            if (v && ready_exp) begin
                partial.push_back(a);
                if (a[7] || partial.size() == BEATS) begin
                    m_word = '0;
                    m_err  = 1'b0;
                    t0     = partial[0][6:4];
                    foreach (partial[i]) begin
                        m_word |= W'(partial[i][3:0]) << (4 * i);
                        if (partial[i][6:4] != t0) m_err = 1'b1;
                    end
                    m_tag    = t0;
                    m_nbeats = CNT_W'(partial.size());
                    m_valid  = 1'b1;
                    partial.delete();
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive_cycle(1'b1, 1'b1, 8'($urandom), 1'b1);
        checks++; if (bus.o_a_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", bus.o_a_ready); end
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.o_valid); end
        checks++; if (bus.o_word !== 16'h0) begin errors++; $display("[TB] FAIL reset_word: got %h expected 0", bus.o_word); end
        checks++; if (bus.o_tag !== 3'd0) begin errors++; $display("[TB] FAIL reset_tag: got %0d expected 0", bus.o_tag); end
        checks++; if (bus.o_nbeats !== 3'd0) begin errors++; $display("[TB] FAIL reset_nbeats: got %0d expected 0", bus.o_nbeats); end
        checks++; if (bus.o_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", bus.o_err); end
        rst           = 1'b0;
        bus.i_a_valid = 1'b0;
        #1;
        checks++; if (bus.o_a_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready: got %b expected 1", bus.o_a_ready); end
    endtask

    task automatic test_basic_word();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 1'b1, {(i == 3), 3'd3, 4'(i + 1)}, 1'b1);
            if (i < 3) begin
                checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_valid beat %0d: got %b expected 0", i, bus.o_valid); end
            end
        end
        checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: got %b expected 1", bus.o_valid); end
        checks++; if (bus.o_word !== 16'h4321) begin errors++; $display("[TB] FAIL basic_word: got %h expected 4321", bus.o_word); end
        checks++; if (bus.o_tag !== 3'd3) begin errors++; $display("[TB] FAIL basic_tag: got %0d expected 3", bus.o_tag); end
        checks++; if (bus.o_nbeats !== 3'd4) begin errors++; $display("[TB] FAIL basic_nbeats: got %0d expected 4", bus.o_nbeats); end
        checks++; if (bus.o_err !== 1'b0) begin errors++; $display("[TB] FAIL basic_err: got %b expected 0", bus.o_err); end
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_drain: got %b expected 0", bus.o_valid); end
    endtask

    task automatic test_short_word();
        drive_cycle(1'b0, 1'b1, {1'b0, 3'd2, 4'h5}, 1'b1);
        drive_cycle(1'b0, 1'b1, {1'b1, 3'd2, 4'h6}, 1'b1);
        checks++; if (bus.o_word !== 16'h0065) begin errors++; $display("[TB] FAIL short_word: got %h expected 0065", bus.o_word); end
        checks++; if (bus.o_nbeats !== 3'd2) begin errors++; $display("[TB] FAIL short_nbeats: got %0d expected 2", bus.o_nbeats); end
        checks++; if (bus.o_tag !== 3'd2) begin errors++; $display("[TB] FAIL short_tag: got %0d expected 2", bus.o_tag); end
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_tag_error();
        logic [2:0] tags[4] = '{3'd1, 3'd1, 3'd4, 3'd1};
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1, {(i == 3), tags[i], 4'($urandom)}, 1'b1);
        checks++; if (bus.o_err !== 1'b1) begin errors++; $display("[TB] FAIL tagerr_err: got %b expected 1", bus.o_err); end
        checks++; if (bus.o_tag !== 3'd1) begin errors++; $display("[TB] FAIL tagerr_tag: got %0d expected 1", bus.o_tag); end
        checks++; if (bus.o_word !== m_word) begin errors++; $display("[TB] FAIL tagerr_word: got %h expected %h", bus.o_word, m_word); end
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1, {(i == 3), 3'd7, 4'($urandom)}, 1'b1);
        checks++; if (bus.o_err !== 1'b0) begin errors++; $display("[TB] FAIL clean_err: got %b expected 0", bus.o_err); end
        checks++; if (bus.o_word !== m_word) begin errors++; $display("[TB] FAIL clean_word: got %h expected %h", bus.o_word, m_word); end
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_backpressure();
        drive_cycle(1'b0, 1'b1, {1'b1, 3'd5, 4'hA}, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b0, 1'b1, {1'b1, 3'd6, 4'h9}, 1'b0);
            checks++; if (bus.o_a_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready cycle %0d: got %b expected 0", i, bus.o_a_ready); end
            checks++; if (bus.o_valid !== 1'b1 || bus.o_word !== 16'h000A || bus.o_tag !== 3'd5) begin
                errors++; $display("[TB] FAIL bp_hold cycle %0d: got v=%b w=%h t=%0d expected v=1 w=000a t=5", i, bus.o_valid, bus.o_word, bus.o_tag);
            end
        end
        drive_cycle(1'b0, 1'b1, {1'b1, 3'd6, 4'h9}, 1'b1);
        checks++; if (bus.o_valid !== 1'b1 || bus.o_word !== 16'h0009 || bus.o_tag !== 3'd6 || bus.o_nbeats !== 3'd1) begin
            errors++; $display("[TB] FAIL bp_release: got v=%b w=%h t=%0d n=%0d expected v=1 w=0009 t=6 n=1", bus.o_valid, bus.o_word, bus.o_tag, bus.o_nbeats);
        end
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_dup: got %b expected 0", bus.o_valid); end
    endtask

    task automatic test_single_beat_stream();
        logic [3:0] n;
        for (int i = 0; i < 10; i++) begin
            n = 4'($urandom);
            drive_cycle(1'b0, 1'b1, {1'b1, 3'($urandom), n}, 1'b1);
            checks++; if (bus.o_valid !== 1'b1 || bus.o_nbeats !== 3'd1 || bus.o_word !== W'(n) || bus.o_err !== 1'b0) begin
                errors++; $display("[TB] FAIL single_beat %0d: got v=%b n=%0d w=%h e=%b expected v=1 n=1 w=%h e=0", i, bus.o_valid, bus.o_nbeats, bus.o_word, bus.o_err, W'(n));
            end
        end
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_reset_midword();
        logic [3:0] n0;
        drive_cycle(1'b0, 1'b1, {1'b0, 3'd4, 4'hE}, 1'b1);
        drive_cycle(1'b0, 1'b1, {1'b0, 3'd4, 4'hD}, 1'b1);
        drive_cycle(1'b1, 1'b0, 8'h00, 1'b1);
        checks++; if (bus.o_valid !== 1'b0 || bus.o_word !== 16'h0 || bus.o_nbeats !== 3'd0) begin
            errors++; $display("[TB] FAIL midreset_clear: got v=%b w=%h n=%0d expected all 0", bus.o_valid, bus.o_word, bus.o_nbeats);
        end
        n0 = 4'($urandom);
        drive_cycle(1'b0, 1'b1, {1'b0, 3'd2, n0}, 1'b1);
        for (int i = 1; i < 4; i++) drive_cycle(1'b0, 1'b1, {1'b0, 3'd2, 4'($urandom)}, 1'b1);
        checks++; if (bus.o_valid !== 1'b1 || bus.o_nbeats !== 3'd4) begin errors++; $display("[TB] FAIL wrap_complete: got v=%b n=%0d expected v=1 n=4", bus.o_valid, bus.o_nbeats); end
        checks++; if (bus.o_word[3:0] !== n0) begin errors++; $display("[TB] FAIL fresh_slot0: got %h expected %h", bus.o_word[3:0], n0); end
        checks++; if (bus.o_word !== m_word) begin errors++; $display("[TB] FAIL fresh_word: got %h expected %h", bus.o_word, m_word); end
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_random();
        logic       v, r, r_rst, lst;
        logic [2:0] t;
        for (int c = 0; c < 600; c++) begin
            v     = ($urandom_range(0, 3) != 0);
            r     = ($urandom_range(0, 3) != 0);
            r_rst = ($urandom_range(0, 99) == 0);
            lst   = ($urandom_range(0, 3) == 0);
            t     = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd2;
            drive_cycle(r_rst, v, {lst, t, 4'($urandom)}, r);
            checks++; if (bus.o_valid !== m_valid) begin errors++; $display("[TB] FAIL rand_valid cycle %0d: got %b expected %b", c, bus.o_valid, m_valid); end
            checks++; if (bus.o_a_ready !== (!rst && (!m_valid || bus.i_ready))) begin
                errors++; $display("[TB] FAIL rand_ready cycle %0d: got %b expected %b", c, bus.o_a_ready, (!rst && (!m_valid || bus.i_ready)));
            end
            if (m_valid) begin
                checks++; if (bus.o_word !== m_word || bus.o_tag !== m_tag || bus.o_nbeats !== m_nbeats || bus.o_err !== m_err) begin
                    errors++; $display("[TB] FAIL rand_word cycle %0d: got w=%h t=%0d n=%0d e=%b expected w=%h t=%0d n=%0d e=%b",
                                       c, bus.o_word, bus.o_tag, bus.o_nbeats, bus.o_err, m_word, m_tag, m_nbeats, m_err);
                end
            end
        end
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        bus.i_a       = 8'h00;
        bus.i_a_valid = 1'b0;
        bus.i_ready   = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_basic_word();
        test_short_word();
        test_tag_error();
        test_backpressure();
        test_single_beat_stream();
        test_reset_midword();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/struct_rx_unpack.md
# struct_rx_unpack

Receive-side endpoint for the 8-bit packed-struct channel. Each beat carries {last, tag, nibble}. The block accepts beats under a valid/ready handshake and assembles up to BEATS nibbles into one word. It then presents the word, its tag, its beat count and a tag-consistency error through a registered valid/ready output stage. It is the consumer that sits opposite the struct-packed channel drivers in `top`-level test harnesses.

## Interface
Parameters:
- BEATS, 4, maximum nibbles per word; legal range 2..8.
- CNT_W, $clog2(BEATS)+1, width of the beat-count output (derived; do not override).

Ports:
- i_clk  in  1  single clock; all state updates on the rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_a  in  8  packed struct: [7] last, [6:4] tag, [3:0] nibble.
- i_a_valid  in  1  input beat valid.
- o_a_ready  out  1  input beat accepted this cycle when high together with i_a_valid.
- o_word  out  4*BEATS  assembled word; nibble k sits at [4k+3:4k].
- o_tag  out  3  tag of the first beat of the word.
- o_nbeats  out  CNT_W  number of beats in the word, 1..BEATS.
- o_err  out  1  high if any beat's tag differed from the first beat's tag.
- o_valid  out  1  output word valid.
- i_ready  in  1  downstream accepts the word when high with o_valid.

## Operation
- Beat transfer: i_a_valid && o_a_ready.
- Output transfer: o_valid && i_ready.
- Readiness:
  - o_a_ready = !i_rst && (!o_valid || i_ready). This is combinational.
  - A completing beat therefore always finds a free or freeing output register.
- Internal accumulator: acc[4*BEATS-1:0], cnt (0..BEATS-1), first_tag[2:0], err_acc.
- On each beat transfer:
  - The nibble is written to acc[4*cnt+3:4*cnt].
  - If cnt==0, first_tag is set to i_a[6:4] and err_acc is cleared. Otherwise err_acc |= (i_a[6:4] != first_tag).
- Word completes on the transferred beat when i_a[7]==1 or cnt==BEATS-1.
- On completion, the output register loads:
  - o_word = acc including the current nibble; nibble slots above the current one are forced to 0.
  - o_tag = first_tag, or the current tag if cnt==0.
  - o_nbeats = cnt+1.
  - o_err = accumulated error OR'd with the current-beat mismatch.
  - o_valid = 1.
  - cnt, acc and err_acc are cleared for the next word.
- On a non-completing beat transfer, cnt increments.
- Output register:
  - When no completion occurs, o_valid clears on an output transfer.
  - All o_* data outputs are held stable while o_valid && !i_ready.
- A single-beat word (last=1 at cnt==0) is legal: o_nbeats=1 and o_err=0.
- The i_a contents are ignored when i_a_valid is low.

## Timing
- Reset: while i_rst is high at a clock edge, the following are cleared:
  - cnt, acc, first_tag and err_acc.
  - o_word, o_tag, o_nbeats, o_err and o_valid, all set to 0.
- o_a_ready is 0 during the cycle i_rst is high and 1 in the first cycle after it.
- Reset mid-word discards the partial word; no output is produced for it.
- Reset while o_valid=1 drops the pending word.
- Latency: completing beat accepted at edge N, then o_valid=1 from edge N onward, i.e. visible in cycle N+1.
- Throughput: one beat per cycle. Back-to-back words need no bubble while i_ready=1.
- Simultaneous completion and output transfer in the same cycle: the new word replaces the old one and o_valid stays 1.
- Backpressure: with o_valid=1 and i_ready=0, o_a_ready=0 and no beats are consumed, including non-completing ones.
- Counter wrap: cnt never exceeds BEATS-1. A beat at cnt==BEATS-1 completes the word regardless of last.

## Test plan
- Reset then 4 beats (last=0,0,0,1), tag 3, nibbles 1,2,3,4 -> o_word=16'h4321, o_tag=3, o_nbeats=3'd4, o_err=0, o_valid one cycle after the 4th beat.
- Beats 5,6 with last on the 2nd beat, tag 2 -> o_word=16'h0065, o_nbeats=2.
- Tags 1,1,4,1 across a 4-beat word -> o_err=1, o_tag=1; the following clean word returns o_err=0.
- Hold i_ready=0 with a word pending and keep i_a_valid=1 -> o_a_ready=0 and outputs stable for 5 cycles. Raise i_ready -> the next word arrives without loss or duplication.
- Continuous 1-beat words (last=1) with i_ready=1 -> o_valid stays high every cycle, o_nbeats=1, and o_word tracks the nibble with 1-cycle latency.
- Assert i_rst after 2 beats of a word -> all outputs 0. A fresh 4-beat word afterwards assembles from nibble slot 0.
